// File: rtl/pkt_commit_ctrl.sv
// Write-side packet sequencer for a snapshot/rollback FIFO.
// Accepts a valid/ready packet stream, writes beats into the FIFO and uses
// the FIFO's snapshot/rollback/reset pointer controls so that only whole,
// error-free packets survive. Packets that carry an error, exceed MAX_LEN
// beats or stall too long on a full FIFO are rolled back and the rest of
// the packet is drained. Commit/drop statistics saturate at all-ones.
module pkt_commit_ctrl #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 16,
    parameter int MAX_LEN     = 16,
    parameter int LENW        = 5,
    parameter int STALL_LIMIT = 64,
    parameter int CNTW        = 16
) (
    input  logic             wrclk,
    input  logic             wr_rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic             in_err,
    input  logic             flush,
    input  logic             fifo_full,
    output logic             write_en,
    output logic [WIDTH-1:0] write_data,
    output logic             snapshot_wrptr,
    output logic             rollback_wrptr,
    output logic             reset_wrptr,
    output logic             pkt_commit,
    output logic             pkt_drop,
    output logic [1:0]       drop_reason,
    output logic [CNTW-1:0]  commit_cnt,
    output logic [CNTW-1:0]  drop_cnt,
    output logic             busy
);

    // A packet can never be longer than the FIFO can hold.
    localparam int EFF_MAX = (MAX_LEN > DEPTH) ? DEPTH : MAX_LEN;
    localparam int SW      = $clog2(STALL_LIMIT + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WRITE    = 2'd1;
    localparam logic [1:0] S_ROLLBACK = 2'd2;
    localparam logic [1:0] S_DROP     = 2'd3;

    localparam logic [1:0] R_ERR   = 2'd0;
    localparam logic [1:0] R_LEN   = 2'd1;
    localparam logic [1:0] R_STALL = 2'd2;
    localparam logic [1:0] R_FLUSH = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [LENW-1:0] len_q, len_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic            eop_seen_q, eop_seen_d;
    logic [1:0]      reason_q, reason_d;
    logic [CNTW-1:0] commit_cnt_q, drop_cnt_q;

    logic beat;
    logic len_full;
    logic stall_expired;

    // Ready is a pure function of state, flush and full, so beat acceptance
    // has no loop through the output decoder.
    assign in_ready = !flush &&
                      (((state_q == S_IDLE) || (state_q == S_WRITE)) ? !fifo_full
                                                                     : (state_q == S_DROP));
    assign beat          = in_valid && in_ready;
    assign len_full      = (len_q == LENW'(EFF_MAX));
    assign stall_expired = (stall_q == SW'(STALL_LIMIT - 1));

    assign write_data  = in_data;
    assign drop_reason = reason_q;
    assign commit_cnt  = commit_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign busy        = (state_q != S_IDLE);

    // State and per-packet bookkeeping registers.
    always_ff @(posedge wrclk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            stall_q    <= '0;
            eop_seen_q <= 1'b0;
            reason_q   <= R_ERR;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            stall_q    <= stall_d;
            eop_seen_q <= eop_seen_d;
            reason_q   <= reason_d;
        end
    end

    // Next-state logic: flush outranks stall timeout, which outranks beats.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        stall_d    = stall_q;
        eop_seen_d = eop_seen_q;
        reason_d   = reason_q;
        if (flush) begin
            if ((state_q == S_WRITE) || (state_q == S_ROLLBACK)) begin
                reason_d = R_FLUSH;
                state_d  = eop_seen_q ? S_IDLE : S_DROP;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (beat && in_sop) begin
                        len_d = LENW'(1);
                        if (in_err) begin
                            state_d    = S_ROLLBACK;
                            reason_d   = R_ERR;
                            eop_seen_d = in_eop;
                        end else if (!in_eop) begin
                            state_d = S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (fifo_full) begin
                        if (stall_expired) begin
                            state_d    = S_ROLLBACK;
                            reason_d   = R_STALL;
                            eop_seen_d = 1'b0;
                        end else begin
                            stall_d = stall_q + 1'b1;
                        end
                    end else begin
                        stall_d = '0;
                        if (beat) begin
                            if (in_err) begin
                                state_d    = S_ROLLBACK;
                                reason_d   = R_ERR;
                                eop_seen_d = in_eop;
                            end else if (len_full) begin
                                state_d    = S_ROLLBACK;
                                reason_d   = R_LEN;
                                eop_seen_d = in_eop;
                            end else begin
                                len_d = len_q + 1'b1;
                                if (in_eop) begin
                                    state_d = S_IDLE;
                                end
                            end
                        end
                    end
                end
                S_ROLLBACK: begin
                    state_d = eop_seen_q ? S_IDLE : S_DROP;
                end
                default: begin
                    if (beat && in_eop) begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
        // Every return to IDLE starts the next packet from a clean slate.
        if (state_d == S_IDLE) begin
            len_d      = '0;
            stall_d    = '0;
            eop_seen_d = 1'b0;
        end
    end

    // Output decode: FIFO strobes and packet pulses for the current cycle.
    always_comb begin
        write_en       = 1'b0;
        snapshot_wrptr = 1'b0;
        rollback_wrptr = 1'b0;
        reset_wrptr    = 1'b0;
        pkt_commit     = 1'b0;
        pkt_drop       = 1'b0;
        if (flush) begin
            reset_wrptr = 1'b1;
            pkt_drop    = (state_q == S_WRITE) || (state_q == S_ROLLBACK);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (beat && in_sop) begin
                        snapshot_wrptr = 1'b1;
                        write_en       = !in_err;
                        pkt_commit     = in_eop && !in_err;
                    end
                end
                S_WRITE: begin
                    if (beat && !in_err && !len_full) begin
                        write_en   = 1'b1;
                        pkt_commit = in_eop;
                    end
                end
                S_ROLLBACK: begin
                    rollback_wrptr = 1'b1;
                    pkt_drop       = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge wrclk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            commit_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            if (pkt_commit && (commit_cnt_q != '1)) begin
                commit_cnt_q <= commit_cnt_q + 1'b1;
            end
            if (pkt_drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: doc/pkt_commit_ctrl.md
Name: pkt_commit_ctrl

Overview:
Write-side packet sequencer for the snapshot/rollback async FIFO, in the FIFO's write clock domain. Accepts a valid/ready packet stream and drives write_en/write_data. It pulses snapshot_wrptr on each start-of-packet and rollback_wrptr when a packet must be discarded (error, oversize, stall timeout), so only whole, good packets remain in the FIFO. A flush request drives reset_wrptr. It keeps commit/drop statistics.

Parameters:
WIDTH, 32, data word width (matches FIFO WIDTH)
DEPTH, 16, FIFO depth in words
MAX_LEN, 16, max packet length in beats (1..DEPTH)
LENW, 5, beat-counter width, holds MAX_LEN
STALL_LIMIT, 64, consecutive full cycles mid-packet before abort
CNTW, 16, statistics counter width

Ports:
wrclk  in  1  write-domain clock
wr_rstn  in  1  asynchronous active-low reset
in_valid  in  1  upstream beat valid
in_ready  out  1  upstream beat accepted when in_valid&&in_ready
in_data  in  WIDTH  beat payload
in_sop  in  1  first beat of packet
in_eop  in  1  last beat of packet
in_err  in  1  beat carries error; packet must be discarded
flush  in  1  discard FIFO contents (reset write pointer)
fifo_full  in  1  FIFO full flag (registered, write domain)
write_en  out  1  FIFO write strobe
write_data  out  WIDTH  FIFO write data (= in_data)
snapshot_wrptr  out  1  capture write pointer
rollback_wrptr  out  1  restore write pointer to snapshot
reset_wrptr  out  1  zero write pointer
pkt_commit  out  1  1-cycle pulse: good packet fully written
pkt_drop  out  1  1-cycle pulse: packet discarded
drop_reason  out  2  last drop cause: 0 ERR, 1 LEN, 2 STALL, 3 FLUSH
commit_cnt  out  CNTW  committed packets, saturating
drop_cnt  out  CNTW  dropped packets, saturating
busy  out  1  state != IDLE

Behaviour:
- Reset (async, wr_rstn low): state IDLE; len, stall, drop_reason, commit_cnt, drop_cnt = 0; all strobes/pulses 0.
- States: IDLE, WRITE, ROLLBACK, DROP. Strobes, in_ready and pulses are combinational from state and current inputs. Counters, state and drop_reason are registered and update on the next wrclk edge.
- Precedence per cycle: flush > stall timeout > beat handling.
- IDLE: in_ready = !fifo_full && !flush.
  - Accepted beat without sop: discarded silently, no write, no pulse.
  - Accepted sop beat: write_en=1 and snapshot_wrptr=1 in the same cycle; len<=1.
    - eop && !err: pkt_commit=1, stay IDLE.
    - err: write_en=0, go ROLLBACK, reason ERR. Snapshot is still taken.
    - !eop && !err: go WRITE.
- WRITE: in_ready = !fifo_full && !flush. in_sop is ignored and the beat is treated as data.
  - Accepted beat with no err, len<MAX_LEN: write_en=1, len++, stall<=0. If eop: pkt_commit=1, go IDLE.
  - Accepted beat with err: not written; go ROLLBACK, reason ERR.
  - Accepted beat with len==MAX_LEN: not written; go ROLLBACK, reason LEN.
  - fifo_full: stall++ each cycle. When stall==STALL_LIMIT-1 and still full: go ROLLBACK, reason STALL.
  - eop_seen flag records whether the aborting beat carried eop.
- ROLLBACK: exactly one cycle.
  - rollback_wrptr=1, write_en=0, in_ready=0.
  - pkt_drop=1; drop_cnt++.
  - Next state: IDLE if eop_seen, else DROP.
- DROP: in_ready=1 (ignores fifo_full); beats are discarded. Accepted eop beat returns to IDLE.
- flush (any state, one cycle):
  - reset_wrptr=1, write_en=0, in_ready=0; rollback_wrptr is suppressed.
  - If state is WRITE or ROLLBACK: pkt_drop=1, drop_cnt++, reason FLUSH, go DROP (IDLE if eop_seen). The drop is counted once even when flush coincides with ROLLBACK.
  - If state is IDLE or DROP: state unchanged, no drop pulse.
- pkt_commit and pkt_drop are mutually exclusive in any cycle.
- Counters saturate at all-ones and never wrap.
- len and stall clear on entry to IDLE.
- Single-beat packet (sop&&eop) commits in one cycle. Snapshot and commit may share a cycle.
- snapshot_wrptr is never asserted outside an accepted sop beat in IDLE.

Test Plan:
- 4-beat good packet, FIFO empty -> write_en 4 cycles, snapshot_wrptr on beat 0 only, pkt_commit on beat 3, commit_cnt=1, no rollback.
- 3-beat packet, err on beat 2 (eop) -> 2 writes, beat 2 not written, ROLLBACK 1 cycle, rollback_wrptr=1, pkt_drop, drop_reason=0, drop_cnt=1, back to IDLE.
- MAX_LEN=16, 20-beat packet -> 16 writes, beat 16 triggers ROLLBACK reason=1, beats 17-19 absorbed in DROP with in_ready=1, IDLE after eop.
- fifo_full held 64 cycles mid-packet (STALL_LIMIT=64) -> in_ready=0 throughout, ROLLBACK on the 64th full cycle, reason=2, then DROP until eop.
- flush during WRITE beat 2 -> reset_wrptr=1 that cycle, write_en=0, pkt_drop reason=3, drop_cnt+1, remaining beats dropped; flush in IDLE -> reset_wrptr only, counters unchanged.
- wr_rstn asserted mid-WRITE -> immediate IDLE, all counters 0, strobes 0; next sop packet commits normally; drop_cnt driven to saturation stays at all-ones.
